// File: rtl/brick_matrix_ctrl.sv
// Brick map owner: turns a missile collision flag into a single brick clear,
// keeps a live brick count and reports each processed hit with a one-cycle pulse.
module brick_matrix_ctrl #(
    parameter int ROWS           = 10,
    parameter int COLS           = 10,
    parameter int BRICK_WIDTH    = 32,
    parameter int BRICK_HEIGHT   = 32,
    parameter int MISSILE_WIDTH  = 10,
    parameter int MISSILE_HEIGHT = 10,
    parameter logic [ROWS*COLS-1:0] INIT_MAP = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         levelLoad,
    input  logic                         hitValid,
    input  logic [10:0]                  missileTopLeftX,
    input  logic [10:0]                  missileTopLeftY,
    input  logic [10:0]                  matrixTopLeftX,
    input  logic [10:0]                  matrixTopLeftY,
    output logic [0:ROWS-1][COLS-1:0]    brickMatrix,
    output logic [6:0]                   bricksLeft,
    output logic                         allCleared,
    output logic                         hitDone,
    output logic                         hitBrick,
    output logic                         busy,
    output logic [1:0]                   debugState
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef logic [0:ROWS-1][COLS-1:0] matrix_t;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, CHECK = 2'd2, HOLD = 2'd3} state_t;

    // Flat level map bit r*COLS+c lands on [row r][col c].
    function automatic matrix_t map_from_flat(input logic [ROWS*COLS-1:0] flat);
        matrix_t m;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                m[r][c] = flat[r*COLS+c];
            end
        end
        return m;
    endfunction

    function automatic logic [6:0] popcount(input logic [ROWS*COLS-1:0] flat);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            cnt = cnt + 7'(flat[i]);
        end
        return cnt;
    endfunction

    localparam matrix_t    INIT_MATRIX = map_from_flat(INIT_MAP);
    localparam logic [6:0] INIT_COUNT  = popcount(INIT_MAP);

    // Handshake: hitValid is a level from the collision checker. One hit is
    // processed per assertion and acknowledged by a one-cycle hitDone with
    // hitBrick valid alongside it; the flag must drop for at least one cycle
    // before another hit is accepted.
    state_t state, next_state;
    logic   latch_en, calc_en, check_en;

    matrix_t     brick_q;
    logic [6:0]  left_q;
    logic        done_q;
    logic        hit_brick_q;
    logic [10:0] mx_q, my_q, ox_q, oy_q;
    logic [11:0] off_x_q, off_y_q;

    logic             in_range;
    logic [ROW_W-1:0] row_idx;
    logic [COL_W-1:0] col_idx;
    logic             hit_cell;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (levelLoad) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        latch_en   = 1'b0;
        calc_en    = 1'b0;
        check_en   = 1'b0;
        case (state)
            IDLE: begin
                if (hitValid) begin
                    latch_en   = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                calc_en    = 1'b1;
                next_state = CHECK;
            end
            CHECK: begin
                check_en   = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                if (!hitValid) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Offsets are two's complement; a set sign bit means left of / above the map.
    always_comb begin
        in_range = !off_x_q[11] && (off_x_q < 12'(COLS*BRICK_WIDTH)) &&
                   !off_y_q[11] && (off_y_q < 12'(ROWS*BRICK_HEIGHT));
        col_idx  = COL_W'(off_x_q / 12'(BRICK_WIDTH));
        row_idx  = ROW_W'(off_y_q / 12'(BRICK_HEIGHT));
        hit_cell = in_range && brick_q[row_idx][col_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brick_q     <= INIT_MATRIX;
            left_q      <= INIT_COUNT;
            done_q      <= 1'b0;
            hit_brick_q <= 1'b0;
            mx_q        <= '0;
            my_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
        end else if (levelLoad) begin
            brick_q     <= INIT_MATRIX;
            left_q      <= INIT_COUNT;
            done_q      <= 1'b0;
            hit_brick_q <= 1'b0;
        end else begin
            done_q <= check_en;
            if (latch_en) begin
                mx_q <= missileTopLeftX;
                my_q <= missileTopLeftY;
                ox_q <= matrixTopLeftX;
                oy_q <= matrixTopLeftY;
            end
            if (calc_en) begin
                off_x_q <= 12'({1'b0, mx_q}) + 12'(MISSILE_WIDTH/2) - 12'({1'b0, ox_q});
                off_y_q <= 12'({1'b0, my_q}) + 12'(MISSILE_HEIGHT/2) - 12'({1'b0, oy_q});
            end
            if (check_en) begin
                hit_brick_q <= hit_cell;
                if (hit_cell) begin
                    brick_q[row_idx][col_idx] <= 1'b0;
                    if (left_q != 7'd0) left_q <= left_q - 7'd1;
                end
            end
        end
    end

    assign brickMatrix = brick_q;
    assign bricksLeft  = left_q;
    assign allCleared  = (left_q == 7'd0);
    assign hitDone     = done_q;
    assign hitBrick    = hit_brick_q;
    assign busy        = (state != IDLE);
    assign debugState  = state;

endmodule
